// File: rtl/modulator_pwm_gen.sv
// PWM modulator: each FIFO sample sets how many steps of a symbol drive pwm high.
// Symbols run back-to-back while the FIFO has data; an empty FIFO at a symbol end is an underflow.
module modulator_pwm_gen #(
   parameter int CLKS_PER_STEP    = 1,
   parameter int STEPS_PER_SYMBOL = 255,
   parameter int BITS_PER_SAMPLE  = 8,
   parameter int UNDERFLOW_HOLD   = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       enable,
   input  logic [BITS_PER_SAMPLE-1:0] sample,
   input  logic                       empty,
   output logic                       read,
   output logic                       pwm,
   output logic                       tc_step,
   output logic                       tc_symb,
   output logic                       underflow,
   output logic                       busy
);

   localparam int CW = (CLKS_PER_STEP > 1) ? $clog2(CLKS_PER_STEP) : 1;
   localparam int SW = (STEPS_PER_SYMBOL > 1) ? $clog2(STEPS_PER_SYMBOL) : 1;
   localparam int XW = (SW > BITS_PER_SAMPLE) ? SW : BITS_PER_SAMPLE;
   localparam logic [CW-1:0] CLK_LAST  = CW'(CLKS_PER_STEP - 1);
   localparam logic [SW-1:0] STEP_LAST = SW'(STEPS_PER_SYMBOL - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      RUNNING = 2'b01
   } state_t;

   state_t                     state_reg, state_next;
   logic [CW-1:0]              clk_cnt_reg, clk_cnt_next;
   logic [SW-1:0]              step_cnt_reg, step_cnt_next;
   logic [BITS_PER_SAMPLE-1:0] sample_reg, sample_next;
   logic                       pwm_reg, pwm_next;
   logic                       running;

   assign running   = (state_reg == RUNNING);
   assign busy      = running;
   assign tc_step   = running && enable && (clk_cnt_reg == CLK_LAST);
   assign tc_symb   = tc_step && (step_cnt_reg == STEP_LAST);
   assign underflow = tc_symb && empty;
   // pwm_reg tracks the frozen position during a pause, so resuming keeps the duty exact
   assign pwm       = pwm_reg && enable;

   always_comb begin
      state_next    = state_reg;
      clk_cnt_next  = clk_cnt_reg;
      step_cnt_next = step_cnt_reg;
      sample_next   = sample_reg;
      read          = 1'b0;
      case (state_reg)
         RUNNING: begin
            if (enable) begin
               if (tc_symb) begin
                  clk_cnt_next  = '0;
                  step_cnt_next = '0;
                  if (!empty) begin
                     read        = 1'b1;
                     sample_next = sample;
                  end else if (UNDERFLOW_HOLD == 0) begin
                     state_next = IDLE;
                  end
               end else if (tc_step) begin
                  clk_cnt_next  = '0;
                  step_cnt_next = step_cnt_reg + 1'b1;
               end else begin
                  clk_cnt_next = clk_cnt_reg + 1'b1;
               end
            end
         end
         default: begin
            state_next    = IDLE;
            clk_cnt_next  = '0;
            step_cnt_next = '0;
            if (enable && !empty && !rst) begin
               read        = 1'b1;
               sample_next = sample;
               state_next  = RUNNING;
            end
         end
      endcase
      // pwm is computed for the position the counters will hold next cycle
      pwm_next = (state_next == RUNNING) && (XW'(step_cnt_next) < XW'(sample_next));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= IDLE;
         clk_cnt_reg  <= '0;
         step_cnt_reg <= '0;
         sample_reg   <= '0;
         pwm_reg      <= 1'b0;
      end else begin
         state_reg    <= state_next;
         clk_cnt_reg  <= clk_cnt_next;
         step_cnt_reg <= step_cnt_next;
         sample_reg   <= sample_next;
         pwm_reg      <= pwm_next;
      end
   end

endmodule

// File: tb/tb_modulator_pwm_gen.sv
// Directed bench for modulator_pwm_gen: two instances (return-to-idle and hold-on-underflow)
// fed by small FIFO models; per-cycle output patterns are compared against hand-derived values.
module tb_modulator_pwm_gen;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       enable = 1'b0;
   logic       rst_next = 1'b1;
   logic       en_next = 1'b0;

   logic [7:0] sample0, sample1;
   logic       empty0, empty1;
   logic       read0, pwm0, tc_step0, tc_symb0, underflow0, busy0;
   logic       read1, pwm1, tc_step1, tc_symb1, underflow1, busy1;

   logic [7:0] q0[$], q1[$], inq0[$], inq1[$];
   logic       pend0 = 1'b0, pend1 = 1'b0;

   logic [31:0] p_pwm, p_rd, p_ts, p_tsy, p_uf, p_busy;
   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   modulator_pwm_gen #(.CLKS_PER_STEP(2), .STEPS_PER_SYMBOL(4), .BITS_PER_SAMPLE(8),
                       .UNDERFLOW_HOLD(0)) u_dut0 (
      .clk(clk), .rst(rst), .enable(enable), .sample(sample0), .empty(empty0),
      .read(read0), .pwm(pwm0), .tc_step(tc_step0), .tc_symb(tc_symb0),
      .underflow(underflow0), .busy(busy0));

   modulator_pwm_gen #(.CLKS_PER_STEP(2), .STEPS_PER_SYMBOL(4), .BITS_PER_SAMPLE(8),
                       .UNDERFLOW_HOLD(1)) u_dut1 (
      .clk(clk), .rst(rst), .enable(enable), .sample(sample1), .empty(empty1),
      .read(read1), .pwm(pwm1), .tc_step(tc_step1), .tc_symb(tc_symb1),
      .underflow(underflow1), .busy(busy1));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end else begin
         $display("ok   %s = %0h", tag, got);
      end
   endtask

   task automatic sync_fifo();
      sample0 = (q0.size() > 0) ? q0[0] : 8'h00;
      empty0  = (q0.size() == 0);
      sample1 = (q1.size() > 0) ? q1[0] : 8'h00;
      empty1  = (q1.size() == 0);
   endtask

   // Inputs change just after the rising edge; outputs are observed just after the falling edge.
   task automatic tick();
      @(posedge clk);
      #1;
      rst    = rst_next;
      enable = en_next;
      if (pend0) q0.delete(0);
      if (pend1) q1.delete(0);
      while (inq0.size() > 0) q0.push_back(inq0.pop_front());
      while (inq1.size() > 0) q1.push_back(inq1.pop_front());
      sync_fifo();
      @(negedge clk);
      #1;
      pend0 = read0;
      pend1 = read1;
      if (read0) check("rd0_not_empty", 32'(empty0), 32'd0);
      if (read1) check("rd1_not_empty", 32'(empty1), 32'd0);
   endtask

   task automatic window(input int n, input bit sel);
      p_pwm = '0; p_rd = '0; p_ts = '0; p_tsy = '0; p_uf = '0; p_busy = '0;
      for (int i = 0; i < n; i++) begin
         tick();
         p_pwm  = {p_pwm[30:0],  sel ? pwm1       : pwm0};
         p_rd   = {p_rd[30:0],   sel ? read1      : read0};
         p_ts   = {p_ts[30:0],   sel ? tc_step1   : tc_step0};
         p_tsy  = {p_tsy[30:0],  sel ? tc_symb1   : tc_symb0};
         p_uf   = {p_uf[30:0],   sel ? underflow1 : underflow0};
         p_busy = {p_busy[30:0], sel ? busy1      : busy0};
      end
   endtask

   initial begin
      sync_fifo();

      // reset held
      tick();
      tick();
      check("rst_outs0", 32'({pwm0, read0, tc_step0, tc_symb0, underflow0, busy0}), 32'd0);
      check("rst_outs1", 32'({pwm1, read1, tc_step1, tc_symb1, underflow1, busy1}), 32'd0);
      rst_next = 1'b0;

      // single sample 3: enable low blocks the pop, then 6 high / 2 low
      inq0.push_back(8'd3);
      tick();
      check("dis_no_read", 32'({read0, busy0}), 32'd0);
      en_next = 1'b1;
      tick();
      check("s3_read", 32'({read0, busy0}), 32'b10);
      window(8, 1'b0);
      check("s3_pwm",   p_pwm,  32'hFC);
      check("s3_tcstp", p_ts,   32'h55);
      check("s3_tcsym", p_tsy,  32'h01);
      check("s3_uf",    p_uf,   32'h01);
      check("s3_busy",  p_busy, 32'hFF);
      check("s3_rd",    p_rd,   32'h00);
      tick();
      check("s3_idle", 32'({busy0, pwm0, read0}), 32'd0);

      // back-to-back 0, 4, 9 with no gap
      inq0.push_back(8'd0);
      inq0.push_back(8'd4);
      inq0.push_back(8'd9);
      tick();
      check("b2b_read0", 32'(read0), 32'd1);
      window(24, 1'b0);
      check("b2b_pwm",   p_pwm,  32'h00FFFF);
      check("b2b_rd",    p_rd,   32'h010100);
      check("b2b_tcsym", p_tsy,  32'h010101);
      check("b2b_uf",    p_uf,   32'h000001);
      check("b2b_busy",  p_busy, 32'hFFFFFF);
      tick();
      check("b2b_idle", 32'({busy0, pwm0}), 32'd0);

      // sample 2, no hold: underflow then idle
      inq0.push_back(8'd2);
      tick();
      check("uf_read", 32'(read0), 32'd1);
      window(8, 1'b0);
      check("uf_pwm", p_pwm, 32'hF0);
      check("uf_uf",  p_uf,  32'h01);
      check("uf_rd",  p_rd,  32'h00);
      tick();
      check("uf_idle", 32'({busy0, pwm0, read0}), 32'd0);

      // pause for 5 clocks inside step 1
      inq0.push_back(8'd3);
      tick();
      check("pz_read", 32'(read0), 32'd1);
      window(3, 1'b0);
      check("pz_pre_pwm", p_pwm, 32'h7);
      en_next = 1'b0;
      window(5, 1'b0);
      check("pz_pwm",  p_pwm,  32'h00);
      check("pz_tc",   p_ts | p_tsy | p_rd | p_uf, 32'h00);
      check("pz_busy", p_busy, 32'h1F);
      en_next = 1'b1;
      window(5, 1'b0);
      check("pz_post_pwm",   p_pwm, 32'h1C);
      check("pz_post_tcstp", p_ts,  32'h15);
      check("pz_post_tcsym", p_tsy, 32'h01);
      tick();
      check("pz_idle", 32'(busy0), 32'd0);

      // asynchronous reset mid-symbol
      inq0.push_back(8'd2);
      inq0.push_back(8'd7);
      tick();
      check("ar_read", 32'(read0), 32'd1);
      window(3, 1'b0);
      check("ar_pre_pwm", p_pwm, 32'h7);
      #2;
      rst      = 1'b1;
      rst_next = 1'b1;
      #1;
      check("ar_async", 32'({pwm0, read0, tc_step0, tc_symb0, underflow0, busy0}), 32'd0);
      tick();
      check("ar_held", 32'({busy0, read0}), 32'd0);
      rst_next = 1'b0;
      tick();
      check("ar_release_read", 32'({read0, busy0}), 32'b10);
      window(8, 1'b0);
      check("ar_pwm", p_pwm, 32'hFF);
      check("ar_uf",  p_uf,  32'h01);

      // hold-on-underflow instance
      inq1.push_back(8'd2);
      tick();
      check("hd_read", 32'(read1), 32'd1);
      window(16, 1'b1);
      check("hd_pwm",  p_pwm,  32'hF0F0);
      check("hd_uf",   p_uf,   32'h0101);
      check("hd_rd",   p_rd,   32'h0000);
      check("hd_busy", p_busy, 32'hFFFF);
      window(4, 1'b1);
      check("hd_mid_pwm", p_pwm, 32'hF);
      inq1.push_back(8'd6);
      window(4, 1'b1);
      check("hd_refill_pwm", p_pwm, 32'h0);
      check("hd_refill_rd",  p_rd,  32'h1);
      check("hd_refill_uf",  p_uf,  32'h0);
      window(8, 1'b1);
      check("hd_new_pwm", p_pwm, 32'hFF);
      check("hd_new_uf",  p_uf,  32'h01);
      check("hd_new_rd",  p_rd,  32'h00);
      en_next = 1'b0;
      tick();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
